instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Sequential instruction encoder and writer that produces 32-bit RV32I words for the instruction memory. The control unit decodes those same words.
- Accepts assembly-level fields (operation, registers, immediate) over a valid/ready handshake, encodes them, and writes one word per accepted item into consecutive instruction-memory addresses.
- Used for test-program loading and self-checking benches. Supports exactly the subset the CPU decodes: addi, bne, sw, lw, plus add.

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction-memory write port; capacity DEPTH = 2^ADDR_WIDTH words.
- START_ADDR, 0, word address of the first write after start.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load session; clears address and count.
- finish  in  1  end the session after any same-cycle transfer.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle.
- in_op  in  3  operation: 000 addi, 001 bne, 010 sw, 011 lw, 100 add; 101–111 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  13  signed immediate. I/S types use bits [11:0]. bne uses a byte offset in [12:0]; bit0 is ignored.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_WIDTH  write word address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_WIDTH+1  words written this session.
- busy  out  1  state is LOAD or PAD.
- done  out  1  session complete.
- err  out  1  sticky illegal-op flag; cleared by start or reset.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; address register = START_ADDR.
- States: IDLE, LOAD, PAD (optional feature only), DONE.
- IDLE:
  - in_ready=0.
  - start -> LOAD; address=START_ADDR, count=0, err=0.
- LOAD:
  - in_ready = !full, where full = (count == DEPTH).
  - Transfer = in_valid & in_ready.
  - Next cycle after a legal-op transfer: mem_we=1 for exactly one cycle, mem_addr = current address, mem_wdata = encoded word. The address then increments (mod DEPTH) and count increments.
  - Latency: one registered stage. Back-to-back transfers yield back-to-back writes.
- Illegal op: the bundle is consumed with in_ready honoured; no write; count unchanged; err set.
- Encodings:
  - addi: I-type, opcode 0010011, funct3 000.
  - lw: I-type, opcode 0000011, funct3 010.
  - sw: S-type, opcode 0100011, funct3 010.
  - bne: B-type, opcode 1100011, funct3 001; imm[12|10:5] in bits 31:25, imm[4:1|11] in bits 11:7.
  - add: R-type, opcode 0110011, funct3 000, funct7 0000000.
  - Fields not used by a type are ignored (e.g. in_rd for sw/bne).
- Leaving LOAD:
  - finish in LOAD (with or without a same-cycle transfer) -> DONE, or PAD if the optional feature is enabled. A same-cycle transfer is still written on the following cycle.
  - When the write that makes count == DEPTH completes -> DONE automatically. in_ready is 0 from the cycle full is reached; later in_valid is ignored.
- DONE:
  - done=1, in_ready=0, count held.
  - start -> LOAD with a fresh session.
  - finish is ignored.
- start while in LOAD restarts the session: any pending registered write still issues; then address and count reset.
- Reset mid-session aborts immediately. No further mem_we. count=0, done=0.

Optional Feature:
- Macro: LOADER_NOP_PAD_EN.
- Enabled:
  - finish in LOAD -> PAD (after any pending write).
  - PAD writes NOP 0x00000013 (addi x0,x0,0) one per cycle to successive addresses until count == DEPTH, then -> DONE.
  - busy=1 and in_ready=0 during PAD.
  - finish when already full goes straight to DONE.
- Disabled: PAD state absent; finish -> DONE directly. Unwritten memory is left untouched.

Test Plan:
- start; send addi rd=1 rs1=0 imm=5 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00500093; count=1.
- Back-to-back bne rs1=1 rs2=0 imm=-4; sw rs2=2 rs1=1 imm=8; lw rd=3 rs1=1 imm=4 -> consecutive writes to addresses 0, 1, 2 of 0xFE009EE3, 0x0020A423, 0x0040A183.
- ADDR_WIDTH=2, in_valid held high with 6 legal ops:
  - Exactly 4 writes, to addresses 0–3.
  - in_ready falls after the 4th acceptance.
  - done=1, count=4.
- in_op=3'b111 among legal ops -> no write for it; err=1 until the next start; addresses remain contiguous.
- finish after 2 writes:
  - Macro off: done, count=2.
  - Macro on with ADDR_WIDTH=2: NOPs 0x00000013 written at addresses 2 and 3, then done, count=4.
- rst_n pulsed low mid-stream -> mem_we=0, busy=0, count=0 immediately; no writes until the next start.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: encodes RV32I field bundles (addi, bne, sw, lw, add) and writes them to consecutive
// instruction-memory words. Define LOADER_NOP_PAD_EN to fill the remaining words with NOPs on finish.
module instr_loader #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned START_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  finish,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [12:0]           in_imm,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] START    = ADDR_WIDTH'(START_ADDR);
   localparam logic [CNT_W-1:0]      FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [31:0]           NOP_WORD = 32'h0000_0013;

   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

`ifdef LOADER_NOP_PAD_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2, S_PAD = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2} state_t;
`endif

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;

   logic [31:0]      enc_word;
   logic             op_legal;
   logic             xfer;
   logic             wr;
   logic [CNT_W-1:0] cnt_inc;
   logic             full;
   logic             full_nxt;

   // Field bundle to RV32I word
   always_comb begin
      enc_word = 32'h0;
      op_legal = 1'b1;
      case (in_op)
         3'd0:    enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_OPIMM};
         3'd1:    enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                              in_imm[4:1], in_imm[11], OPC_BRANCH};
         3'd2:    enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
         3'd3:    enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
         3'd4:    enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_OP};
         default: op_legal = 1'b0;
      endcase
   end

   // Handshake and fill status; full_nxt accounts for a write launched this cycle
   always_comb begin
      xfer     = (state == S_LOAD) && in_valid && in_ready;
      wr       = xfer && op_legal;
      cnt_inc  = count + CNT_W'(1);
      full     = (count == FULL_CNT);
      full_nxt = wr ? (cnt_inc == FULL_CNT) : full;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr      <= START;
         count     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         // Accepted legal bundle is written on the next cycle, even if the state changes now
         if (wr) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= enc_word;
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_LOAD;
                  addr     <= START;
                  count    <= '0;
                  err      <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end

            S_LOAD: begin
               if (xfer && !op_legal) err <= 1'b1;
               if (start) begin
                  addr     <= START;
                  count    <= '0;
                  err      <= 1'b0;
                  in_ready <= 1'b1;
               end else begin
                  if (wr) begin
                     addr  <= addr + ADDR_WIDTH'(1);
                     count <= cnt_inc;
                  end
                  if (finish || full) begin
                     in_ready <= 1'b0;
`ifdef LOADER_NOP_PAD_EN
                     if (finish && !full_nxt) begin
                        state <= S_PAD;
                     end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
`else
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
`endif
                  end else begin
                     in_ready <= !full_nxt;
                  end
               end
            end

`ifdef LOADER_NOP_PAD_EN
            // One NOP per cycle until memory is full
            S_PAD: begin
               if (start) begin
                  state    <= S_LOAD;
                  addr     <= START;
                  count    <= '0;
                  err      <= 1'b0;
                  in_ready <= 1'b1;
               end else if (full) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  mem_we    <= 1'b1;
                  mem_addr  <= addr;
                  mem_wdata <= NOP_WORD;
                  addr      <= addr + ADDR_WIDTH'(1);
                  count     <= cnt_inc;
               end
            end
`endif

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: vector table, hand sequences and randomized sessions against a field-level encoder model.
module tb_instr_loader;

   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 1 << AW;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          finish;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [4:0]    in_rd;
   logic [4:0]    in_rs1;
   logic [4:0]    in_rs2;
   logic [12:0]   in_imm;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW:0]   count;
   logic          busy;
   logic          done;
   logic          err;

   instr_loader #(.ADDR_WIDTH(AW), .START_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          wr_cyc_q[$];
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      cyc++;
      if (mem_we === 1'b1) begin
         wr_addr_q.push_back(32'(mem_addr));
         wr_data_q.push_back(mem_wdata);
         wr_cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference encoder built from bit positions with plain arithmetic
   function automatic logic [32:0] ref_enc(input logic [2:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [12:0] imm);
      int unsigned d, s1, s2, i12, b, w;
      d   = 32'(rd);
      s1  = 32'(rs1);
      s2  = 32'(rs2);
      b   = 32'(imm);
      i12 = b % 4096;
      case (op)
         3'd0: w = (i12 << 20) | (s1 << 15) | (d << 7) | 32'h13;
         3'd1: w = (((b >> 12) % 2) << 31) | (((b >> 5) % 64) << 25) | (s2 << 20) | (s1 << 15)
                   | (32'd1 << 12) | (((b >> 1) % 16) << 8) | (((b >> 11) % 2) << 7) | 32'h63;
         3'd2: w = ((i12 / 32) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12)
                   | ((i12 % 32) << 7) | 32'h23;
         3'd3: w = (i12 << 20) | (s1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
         3'd4: w = (s2 << 20) | (s1 << 15) | (d << 7) | 32'h33;
         default: return {1'b0, 32'h0};
      endcase
      return {1'b1, 32'(w)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      exp_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm, input logic fin,
                        input logic exp_ready);
      in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      finish   = fin;
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      tick();
      in_valid = 1'b0;
      finish   = 1'b0;
   endtask

   // Ends a session (optionally asserting finish) and compares every captured write
   task automatic close_session(input string tag, input logic do_finish, input logic exp_err);
      int n;
      int lim;
      if (do_finish) begin
         finish = 1'b1;
         tick();
         finish = 1'b0;
      end
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, " done"}, 32'(done), 32'd1);
      repeat (2) tick();
`ifdef LOADER_NOP_PAD_EN
      while (exp_q.size() < DEPTH) exp_q.push_back(NOP);
`endif
      chk({tag, " count"}, 32'(count), 32'(exp_q.size()));
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " err"}, 32'(err), 32'(exp_err));
      chk({tag, " nwrites"}, 32'(wr_data_q.size()), 32'(exp_q.size()));
      lim = (wr_data_q.size() < exp_q.size()) ? wr_data_q.size() : exp_q.size();
      for (int i = 0; i < lim; i++) begin
         chk({tag, " addr"}, wr_addr_q[i], 32'(i % DEPTH));
         chk({tag, " data"}, wr_data_q[i], exp_q[i]);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [12:0] imm;
      logic        legal;
      logic [31:0] word;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [32:0] r;
      logic [2:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [12:0] imm;
      int          legal_cnt;
      logic        any_err;
      int          nitems;
      logic        fin_last;

      vecs[0] = '{3'd0, 5'd1, 5'd0, 5'd0, 13'd5,      1'b1, 32'h0050_0093};
      vecs[1] = '{3'd1, 5'd9, 5'd1, 5'd0, 13'h1FFC,   1'b1, 32'hFE00_9EE3};
      vecs[2] = '{3'd2, 5'd9, 5'd1, 5'd2, 13'd8,      1'b1, 32'h0020_A423};
      vecs[3] = '{3'd3, 5'd3, 5'd1, 5'd7, 13'd4,      1'b1, 32'h0040_A183};
      vecs[4] = '{3'd4, 5'd5, 5'd6, 5'd7, 13'h0ABC,   1'b1, 32'h0073_02B3};
      vecs[5] = '{3'd0, 5'd2, 5'd2, 5'd0, 13'h1FFF,   1'b1, 32'hFFF1_0113};
      vecs[6] = '{3'd1, 5'd0, 5'd3, 5'd4, 13'd8,      1'b1, 32'h0041_9463};
      vecs[7] = '{3'd7, 5'd1, 5'd1, 5'd1, 13'd1,      1'b0, 32'h0};

      rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
      in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      repeat (3) tick();
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst mem_addr", 32'(mem_addr), 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'd0);
      chk("rst count", 32'(count), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle in_ready", 32'(in_ready), 32'd0);

      // First write appears exactly one cycle after the handshake
      do_start();
      chk("start busy", 32'(busy), 32'd1);
      drive(3'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0, 1'b1);
      chk("addi mem_we", 32'(mem_we), 32'd1);
      chk("addi mem_addr", 32'(mem_addr), 32'd0);
      chk("addi mem_wdata", mem_wdata, 32'h0050_0093);
      chk("addi count", 32'(count), 32'd1);
      tick();
      chk("addi we pulse", 32'(mem_we), 32'd0);
      exp_q.push_back(32'h0050_0093);
      close_session("addi", 1'b1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         do_start();
         drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b0, 1'b1);
         if (vecs[i].legal) exp_q.push_back(vecs[i].word);
         close_session($sformatf("vec%0d", i), 1'b1, !vecs[i].legal);
      end

      // Back-to-back transfers give writes on consecutive cycles
      do_start();
      drive(3'd1, 5'd0, 5'd1, 5'd0, 13'h1FFC, 1'b0, 1'b1);
      drive(3'd2, 5'd0, 5'd1, 5'd2, 13'd8, 1'b0, 1'b1);
      drive(3'd3, 5'd3, 5'd1, 5'd0, 13'd4, 1'b0, 1'b1);
      exp_q.push_back(32'hFE00_9EE3);
      exp_q.push_back(32'h0020_A423);
      exp_q.push_back(32'h0040_A183);
      close_session("b2b", 1'b1, 1'b0);
      if (wr_cyc_q.size() >= 3) begin
         chk("b2b cyc1", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd1);
         chk("b2b cyc2", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 32'd1);
      end

      // Six legal ops with valid held: only DEPTH accepted, auto-complete
      do_start();
      for (int i = 0; i < 6; i++) begin
         op = 3'($urandom_range(0, 4));
         rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); imm = 13'($urandom);
         r = ref_enc(op, rd, rs1, rs2, imm);
         if (i < DEPTH) exp_q.push_back(r[31:0]);
         drive(op, rd, rs1, rs2, imm, 1'b0, i < DEPTH);
      end
      close_session("full", 1'b0, 1'b0);
      chk("full done sticky", 32'(done), 32'd1);

      // Illegal op consumed without a write; err sticky until start
      do_start();
      drive(3'd0, 5'd4, 5'd0, 5'd0, 13'd7, 1'b0, 1'b1);
      drive(3'd7, 5'd4, 5'd4, 5'd4, 13'd7, 1'b0, 1'b1);
      chk("illegal err", 32'(err), 32'd1);
      drive(3'd4, 5'd5, 5'd6, 5'd7, 13'd0, 1'b0, 1'b1);
      exp_q.push_back(ref_enc(3'd0, 5'd4, 5'd0, 5'd0, 13'd7) & 33'hFFFF_FFFF);
      exp_q.push_back(32'h0073_02B3);
      close_session("illegal", 1'b1, 1'b1);
      chk("illegal err held", 32'(err), 32'd1);

      // Finish after two writes
      do_start();
      chk("restart err", 32'(err), 32'd0);
      chk("restart count", 32'(count), 32'd0);
      drive(3'd0, 5'd1, 5'd0, 5'd0, 13'd1, 1'b0, 1'b1);
      drive(3'd0, 5'd2, 5'd0, 5'd0, 13'd2, 1'b0, 1'b1);
      exp_q.push_back(32'h0010_0093);
      exp_q.push_back(32'h0020_0113);
      close_session("fin2", 1'b1, 1'b0);

      // Reset mid-stream aborts the pending write immediately
      do_start();
      drive(3'd0, 5'd1, 5'd0, 5'd0, 13'd3, 1'b0, 1'b1);
      drive(3'd0, 5'd2, 5'd0, 5'd0, 13'd4, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort mem_we", 32'(mem_we), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort count", 32'(count), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      wr_data_q.delete();
      wr_addr_q.delete();
      tick();
      rst_n = 1'b1;
      in_valid = 1'b1;
      repeat (4) tick();
      chk("abort in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      chk("abort nwrites", 32'(wr_data_q.size()), 32'd0);
      chk("abort addr reset", 32'(count), 32'd0);

      // Randomized sessions against the model
      for (int s = 0; s < 40; s++) begin
         do_start();
         legal_cnt = 0;
         any_err   = 1'b0;
         nitems    = $urandom_range(1, 7);
         fin_last  = 1'($urandom_range(0, 1));
         for (int k = 0; k < nitems; k++) begin
            op  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); imm = 13'($urandom);
            r   = ref_enc(op, rd, rs1, rs2, imm);
            if (legal_cnt < DEPTH) begin
               if (r[32]) begin
                  exp_q.push_back(r[31:0]);
                  legal_cnt++;
               end else begin
                  any_err = 1'b1;
               end
               drive(op, rd, rs1, rs2, imm, fin_last && (k == nitems - 1), 1'b1);
            end else begin
               drive(op, rd, rs1, rs2, imm, fin_last && (k == nitems - 1), 1'b0);
            end
            repeat ($urandom_range(0, 2)) tick();
         end
         close_session($sformatf("rnd%0d", s), !fin_last, any_err);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
